qspi_target_model: RTL and testbench

- Synthesizable QSPI target (flash-responder) that answers the SoC's QSPI master, for FPGA loopback and simulation without an external flash part.
- Oversamples the master's SCLK/CS_n on the local clock and decodes a fixed command set.
- Serves quad reads from, and accepts quad programs into, an internal byte array.
- Tristate control uses the same convention as the SoC pads: oen high = input, low = output.

---
 rtl/qspi_target_model.sv | 221 ++++++++++++++++++++++
 tb/tb_qspi_target_model.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qspi_target_model.sv
// QSPI flash responder: oversamples the master's SCLK/CS_n on clk_i and serves
// quad read (0xEB), quad program (0x38) and JEDEC ID (0x9F) from an internal byte array.
module qspi_target_model #(
  parameter int          MEM_BYTES    = 4096,
  parameter int          DUMMY_CYCLES = 6,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       qspi_sclk_i,
  input  logic       qspi_cs_ni,
  input  logic [3:0] qspi_data_i,
  output logic [3:0] qspi_data_o,
  output logic [3:0] qspi_data_oen,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_o,
  output logic       cmd_err_o
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_ID, S_IGNORE
  } state_e;

  logic [2:0]    sclk_sync_q;
  logic [1:0]    cs_sync_q;
  logic [3:0]    data_sync1_q, data_sync2_q;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_read_q, is_read_d;
  logic          nib_sel_q, nib_sel_d;
  logic [3:0]    hi_q, hi_d;
  logic [3:0]    data_o_q, data_o_d;
  logic [3:0]    oen_q, oen_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_err_q, cmd_err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    rdata_q;

  logic          rise_s, fall_s, cs_high_s, id_bit_s;
  logic [3:0]    nib_s;
  logic [7:0]    cmd_byte_s;

  // IO is registered in step with SCLK so a detected rise sees the matching data
  assign rise_s     = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall_s     = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_high_s  = cs_sync_q[1];
  assign nib_s      = data_sync2_q;
  assign cmd_byte_s = {shreg_q, nib_s[0]};
  assign id_bit_s   = (cnt_q < 8'd24) ? JEDEC_ID[5'd23 - cnt_q[4:0]] : 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    nib_sel_d   = nib_sel_q;
    hi_d        = hi_q;
    data_o_d    = data_o_q;
    oen_d       = oen_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = cmd_err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // CS_n high overrides any edge seen in the same cycle
    if (cs_high_s) begin
      state_d   = S_IDLE;
      oen_d     = 4'hF;
      cnt_d     = 8'd0;
      nib_sel_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_CMD;
          cnt_d     = 8'd0;
          nib_sel_d = 1'b0;
          oen_d     = 4'hF;
        end
        S_CMD: if (rise_s) begin
          shreg_d = cmd_byte_s[6:0];
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d       = 8'd0;
            cmd_valid_d = 1'b1;
            cmd_d       = cmd_byte_s;
            case (cmd_byte_s)
              8'hEB: begin state_d = S_ADDR; is_read_d = 1'b1; end
              8'h38: begin state_d = S_ADDR; is_read_d = 1'b0; end
              8'h9F: state_d = S_ID;
              default: begin state_d = S_IGNORE; cmd_err_d = 1'b1; end
            endcase
          end
        end
        S_ADDR: if (rise_s) begin
          // Only the low address bits survive the shift, which gives the modulo wrap
          addr_d = AW'({addr_q, nib_s});
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d     = 8'd0;
            nib_sel_d = 1'b0;
            state_d   = !is_read_q ? S_WDATA :
                        (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
          end
        end
        S_DUMMY: if (rise_s) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
            cnt_d   = 8'd0;
            state_d = S_RDATA;
          end
        end
        S_RDATA: if (fall_s) begin
          oen_d = 4'h0;
          if (!nib_sel_q) begin
            data_o_d  = rdata_q[7:4];
            nib_sel_d = 1'b1;
          end else begin
            data_o_d  = rdata_q[3:0];
            nib_sel_d = 1'b0;
            addr_d    = addr_q + AW'(1);
          end
        end
        S_WDATA: if (rise_s) begin
          if (!nib_sel_q) begin
            hi_d      = nib_s;
            nib_sel_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {hi_q, nib_s};
            addr_d    = addr_q + AW'(1);
            nib_sel_d = 1'b0;
          end
        end
        S_ID: if (fall_s) begin
          oen_d    = 4'b1101;
          data_o_d = {2'b00, id_bit_s, 1'b0};
          if (cnt_q < 8'd24) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_IGNORE: oen_d = 4'hF;
        default: begin
          state_d = S_IDLE;
          oen_d   = 4'hF;
        end
      endcase
    end
  end

  // Synchronizers, FSM state and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q  <= 3'b000;
      cs_sync_q    <= 2'b11;
      data_sync1_q <= 4'h0;
      data_sync2_q <= 4'h0;
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      shreg_q      <= 7'd0;
      addr_q       <= '0;
      is_read_q    <= 1'b0;
      nib_sel_q    <= 1'b0;
      hi_q         <= 4'h0;
      data_o_q     <= 4'h0;
      oen_q        <= 4'hF;
      cmd_q        <= 8'h00;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], qspi_sclk_i};
      cs_sync_q    <= {cs_sync_q[0], qspi_cs_ni};
      data_sync1_q <= qspi_data_i;
      data_sync2_q <= data_sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      addr_q       <= addr_d;
      is_read_q    <= is_read_d;
      nib_sel_q    <= nib_sel_d;
      hi_q         <= hi_d;
      data_o_q     <= data_o_d;
      oen_q        <= oen_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_err_q    <= cmd_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Array is read every cycle so the byte at addr_q is ready before the next fall
  always_ff @(posedge clk_i) begin
    if (wr_en_q) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
    rdata_q <= mem_q[addr_q];
  end

  assign qspi_data_o   = data_o_q;
  assign qspi_data_oen = oen_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_o         = cmd_q;
  assign cmd_err_o     = cmd_err_q;

endmodule

// File: tb/tb_qspi_target_model.sv
// Bench acting as the QSPI master; expected IO nibbles and command bytes are queued
// by the stimulus and checked by independent monitors against a byte-array model.
module tb_qspi_target_model;
  localparam int MEM   = 4096;
  localparam int DUMMY = 6;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       qspi_sclk_i = 1'b0;
  logic       qspi_cs_ni = 1'b1;
  logic [3:0] qspi_data_i = 4'h0;
  logic [3:0] qspi_data_o, qspi_data_oen;
  logic       cmd_valid_o, cmd_err_o;
  logic [7:0] cmd_o;

  typedef struct packed {logic [3:0] oen; logic [3:0] dat;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] cmd_exp_q[$];
  logic [7:0] model_mem [MEM];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;

  qspi_target_model #(.MEM_BYTES(MEM), .DUMMY_CYCLES(DUMMY), .JEDEC_ID(24'hEF4018)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .qspi_sclk_i(qspi_sclk_i), .qspi_cs_ni(qspi_cs_ni),
    .qspi_data_i(qspi_data_i), .qspi_data_o(qspi_data_o), .qspi_data_oen(qspi_data_oen),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_err_o(cmd_err_o));

  always #5 clk_i = ~clk_i;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // IO monitor: master samples on SCLK rise; any drive must match the queued nibble
  always @(posedge qspi_sclk_i) begin
    if (!qspi_cs_ni && !reset_i && qspi_data_oen !== 4'hF) begin
      if (exp_q.size() == 0) begin
        chk("drive_unexpected", {28'd0, qspi_data_oen}, 32'hF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("io_oen", {28'd0, qspi_data_oen}, {28'd0, mon_e.oen});
        chk("io_data", {28'd0, qspi_data_o & ~qspi_data_oen}, {28'd0, mon_e.dat & ~mon_e.oen});
      end
    end
  end

  // Command monitor
  always @(negedge clk_i) begin
    if (!reset_i && cmd_valid_o) begin
      if (cmd_exp_q.size() == 0) chk("cmd_valid_spurious", {31'd0, cmd_valid_o}, 32'd0);
      else chk("cmd_byte", {24'd0, cmd_o}, {24'd0, cmd_exp_q.pop_front()});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: timeout reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic sclk_cycle(input logic [3:0] io);
    qspi_data_i = io;
    #60 qspi_sclk_i = 1'b1;
    #60 qspi_sclk_i = 1'b0;
  endtask

  task automatic cs_low();
    qspi_cs_ni = 1'b0;
    #120;
  endtask

  task automatic cs_high();
    #60;
    chk("io_queue_drained", exp_q.size(), 32'd0);
    chk("cmd_queue_drained", cmd_exp_q.size(), 32'd0);
    exp_q.delete();
    cmd_exp_q.delete();
    qspi_cs_ni = 1'b1;
    #200;
    chk("oen_after_cs", {28'd0, qspi_data_oen}, 32'hF);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_exp_q.push_back(c);
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, c[i]});
  endtask

  task automatic send_addr(input int a);
    logic [23:0] a24;
    a24 = a[23:0];
    for (int n = 5; n >= 0; n--) sclk_cycle(a24[n*4 +: 4]);
  endtask

  // Programs n bytes taken MSB-first from d
  task automatic do_program(input int a, input logic [31:0] d, input int n);
    logic [7:0] b;
    cs_low();
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      b = d[8*(n-1-i) +: 8];
      sclk_cycle(b[7:4]);
      sclk_cycle(b[3:0]);
      model_mem[(a + i) % MEM] = b;
    end
    cs_high();
  endtask

  task automatic read_preamble(input int a);
    cs_low();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < DUMMY; i++) sclk_cycle(4'h0);
  endtask

  task automatic do_read(input int a, input int n);
    logic [7:0] b;
    read_preamble(a);
    for (int i = 0; i < n; i++) begin
      b = model_mem[(a + i) % MEM];
      exp_q.push_back({4'h0, b[7:4]});
      exp_q.push_back({4'h0, b[3:0]});
    end
    for (int i = 0; i < 2 * n; i++) sclk_cycle(4'($urandom_range(0, 15)));
    cs_high();
  endtask

  initial begin
    logic [23:0] id;
    logic [7:0]  b;
    int          a, n;
    id = 24'hEF4018;
    #23;
    chk("rst_oen", {28'd0, qspi_data_oen}, 32'hF);
    chk("rst_data_o", {28'd0, qspi_data_o}, 32'h0);
    chk("rst_cmd_o", {24'd0, cmd_o}, 32'h0);
    chk("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'h0);
    chk("rst_cmd_err", {31'd0, cmd_err_o}, 32'h0);
    reset_i = 1'b0;
    #100;

    do_program(32'h10, 32'hA53C, 2);
    do_read(32'h10, 2);

    // JEDEC ID on IO1, then IO1 held high
    cs_low();
    send_cmd(8'h9F);
    for (int i = 23; i >= 0; i--) exp_q.push_back({4'b1101, 2'b00, id[i], 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({4'b1101, 4'b0010});
    for (int i = 0; i < 32; i++) sclk_cycle(4'h0);
    chk("id_cmd_held", {24'd0, cmd_o}, 32'h9F);
    cs_high();

    do_program(MEM - 1, 32'hFF11, 2);
    do_read(MEM - 1, 2);

    cs_low();
    send_cmd(8'h05);
    for (int i = 0; i < 16; i++) sclk_cycle(4'($urandom_range(0, 15)));
    chk("cmd_err_set", {31'd0, cmd_err_o}, 32'd1);
    cs_high();
    do_read(32'h10, 2);
    chk("cmd_err_sticky", {31'd0, cmd_err_o}, 32'd1);

    // Abort after three program nibbles: only the first byte lands
    do_program(32'h20, 32'h1122, 2);
    cs_low();
    send_cmd(8'h38);
    send_addr(32'h20);
    sclk_cycle(4'h7);
    sclk_cycle(4'h7);
    sclk_cycle(4'h9);
    model_mem[32'h20] = 8'h77;
    cs_high();
    do_read(32'h20, 2);

    for (int t = 0; t < 12; t++) begin
      a = int'($urandom_range(0, MEM - 1));
      n = int'($urandom_range(1, 4));
      do_program(a, $urandom, n);
      do_read(a, n);
    end

    // Async reset in the middle of a read
    read_preamble(32'h10);
    b = model_mem[32'h10];
    exp_q.push_back({4'h0, b[7:4]});
    exp_q.push_back({4'h0, b[3:0]});
    sclk_cycle(4'h0);
    sclk_cycle(4'h0);
    reset_i = 1'b1;
    #1;
    chk("arst_oen", {28'd0, qspi_data_oen}, 32'hF);
    chk("arst_cmd_o", {24'd0, cmd_o}, 32'h0);
    chk("arst_data_o", {28'd0, qspi_data_o}, 32'h0);
    chk("arst_cmd_err", {31'd0, cmd_err_o}, 32'h0);
    chk("arst_io_queue", exp_q.size(), 32'd0);
    chk("arst_cmd_queue", cmd_exp_q.size(), 32'd0);
    exp_q.delete();
    cmd_exp_q.delete();
    #9;
    qspi_cs_ni = 1'b1;
    #100;
    reset_i = 1'b0;
    #200;
    do_read(32'h10, 2);
    do_read(MEM - 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
